// File: rtl/dmem_ws_if.sv
// Request/response bus between the data-path memory port and the dmem_ws wait-state memory.
interface dmem_ws_if;
  logic        req;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic        ready;
  logic [31:0] read_data;
  logic        busy;
  logic        err;

  modport master (
    output req, we, be, addr, write_data,
    input  ready, read_data, busy, err
  );

  modport slave (
    input  req, we, be, addr, write_data,
    output ready, read_data, busy, err
  );
endinterface

// File: rtl/dmem_ws.sv
// Wait-state data memory with req/ready handshake, byte-lane writes and a registered read port.
// Optional out-of-range error reporting is enabled by defining DMEM_WS_ERR_EN.
module dmem_ws #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned WAIT  = 2
) (
  input logic     clk,
  input logic     reset,
  dmem_ws_if.slave bus
);

  localparam int unsigned Aw = $clog2(DEPTH);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e          state_q;
  logic [3:0]      cnt_q;
  logic            we_q;
  logic [3:0]      be_q;
  logic [Aw-1:0]   idx_q;
  logic [31:0]     wdata_q;
  logic            oob_q;
  logic            ready_q;
  logic            busy_q;
  logic            err_q;
  logic [31:0]     rdata_q;

  logic [31:0]     mem [DEPTH];

  logic            accept;
  logic            commit;
  logic            in_oob;
  logic            c_we;
  logic            c_oob;
  logic [3:0]      c_be;
  logic [Aw-1:0]   c_idx;
  logic [31:0]     c_wdata;

  logic            unused_addr;
  assign unused_addr = ^{bus.addr[1:0], bus.addr[31:Aw+2]};

  assign accept = (state_q == StIdle) && bus.req;

`ifdef DMEM_WS_ERR_EN
  assign in_oob = |bus.addr[31:Aw+2];
`else
  assign in_oob = 1'b0;
`endif

  // With no wait states the commit edge is the acceptance edge, so use the live inputs.
  always_comb begin
    commit  = 1'b0;
    c_we    = we_q;
    c_be    = be_q;
    c_idx   = idx_q;
    c_wdata = wdata_q;
    c_oob   = oob_q;
    if (WAIT == 0) begin
      commit  = accept;
      c_we    = bus.we;
      c_be    = bus.be;
      c_idx   = bus.addr[Aw+1:2];
      c_wdata = bus.write_data;
      c_oob   = in_oob;
    end else begin
      commit  = (state_q == StWait) && (cnt_q == 4'd1);
    end
  end

  // Gated by reset so a reset that coincides with the commit edge blocks the store.
  always_ff @(posedge clk) begin
    if (!reset && commit && c_we && !c_oob) begin
      for (int i = 0; i < 4; i++) begin
        if (c_be[i]) mem[c_idx][8*i +: 8] <= c_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      be_q    <= 4'd0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      oob_q   <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.req) begin
            we_q    <= bus.we;
            be_q    <= bus.be;
            idx_q   <= bus.addr[Aw+1:2];
            wdata_q <= bus.write_data;
            oob_q   <= in_oob;
            cnt_q   <= 4'(WAIT);
            busy_q  <= 1'b1;
            state_q <= (WAIT == 0) ? StResp : StWait;
          end
        end
        StWait: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_q <= StResp;
        end
        StResp: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
      if (commit) begin
        ready_q <= 1'b1;
        err_q   <= c_oob;
        if (!c_we) rdata_q <= c_oob ? 32'd0 : mem[c_idx];
      end
    end
  end

  assign bus.ready     = ready_q;
  assign bus.busy      = busy_q;
  assign bus.read_data = rdata_q;
`ifdef DMEM_WS_ERR_EN
  assign bus.err       = err_q;
`else
  logic unused_err;
  assign unused_err = err_q;
  assign bus.err       = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_ws.sv
// Self-checking bench for dmem_ws: vector table plus hand sequences, scoreboard on ready.
module tb_dmem_ws;

`ifdef DMEM_WS_ERR_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  logic clk;
  logic reset;
  int   total;
  int   bad;
  int   cyc;
  int   rdy0;
  int   rdy1;

  typedef struct packed {
    logic        is_read;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  exp_t q0[$];
  exp_t q1[$];
  int   st0[$];
  exp_t m0;
  exp_t m1;
  vec_t tbl[14];

  dmem_ws_if bus0 ();
  dmem_ws_if bus1 ();

  dmem_ws #(.DEPTH(64), .WAIT(2)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
  dmem_ws #(.DEPTH(64), .WAIT(0)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (bus0.ready === 1'b1) begin
      rdy0++;
      st0.push_back(cyc);
      check("ready0_expected", 32'(q0.size() != 0), 32'd1);
      if (q0.size() != 0) begin
        m0 = q0.pop_front();
        if (m0.is_read) check("rdata0", bus0.read_data, m0.rdata);
        check("err0", 32'(bus0.err), 32'(m0.err));
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (bus1.ready === 1'b1) begin
      rdy1++;
      check("ready1_expected", 32'(q1.size() != 0), 32'd1);
      if (q1.size() != 0) begin
        m1 = q1.pop_front();
        if (m1.is_read) check("rdata1", bus1.read_data, m1.rdata);
        check("err1", 32'(bus1.err), 32'(m1.err));
      end
    end
  end

  task automatic drive(input int sel, input logic req, input logic we, input logic [3:0] be,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (sel == 0) begin
      bus0.req = req; bus0.we = we; bus0.be = be; bus0.addr = addr; bus0.write_data = wdata;
    end else begin
      bus1.req = req; bus1.we = we; bus1.be = be; bus1.addr = addr; bus1.write_data = wdata;
    end
  endtask

  task automatic txn(input int sel, input logic we, input logic [3:0] be, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] rdata, input logic err,
                     input int lat);
    exp_t e;
    int   k;
    logic r;
    e = '{is_read: !we, rdata: rdata, err: err};
    @(negedge clk);
    drive(sel, 1'b1, we, be, addr, wdata);
    @(posedge clk);
    if (sel == 0) q0.push_back(e); else q1.push_back(e);
    #1;
    // Scramble the inputs after acceptance; the latched fields must not follow them.
    drive(sel, 1'b0, ~we, ~be, addr ^ 32'h4, ~wdata);
    k = 1;
    r = (sel == 0) ? bus0.ready : bus1.ready;
    while (r !== 1'b1 && k < 20) begin
      @(posedge clk);
      #1;
      k++;
      r = (sel == 0) ? bus0.ready : bus1.ready;
    end
    check((sel == 0) ? "latency0" : "latency1", 32'(k), 32'(lat));
    @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rb;
    total = 0; bad = 0; cyc = 0; rdy0 = 0; rdy1 = 0;
    drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);

    tbl[0]  = '{1'b1, 4'b1111, 32'h14,  32'h12345678, 32'h0, 1'b0};
    tbl[1]  = '{1'b0, 4'b0000, 32'h14,  32'h0, 32'h12345678, 1'b0};
    tbl[2]  = '{1'b1, 4'b0010, 32'h14,  32'h0000AB00, 32'h0, 1'b0};
    tbl[3]  = '{1'b0, 4'b1111, 32'h14,  32'h0, 32'h1234AB78, 1'b0};
    tbl[4]  = '{1'b1, 4'b1111, 32'h0,   32'h00C0FFEE, 32'h0, 1'b0};
    tbl[5]  = '{1'b1, 4'b1111, 32'h100, 32'hDEADBEEF, 32'h0, ErrEn};
    tbl[6]  = '{1'b0, 4'b0000, 32'h0,   32'h0, ErrEn ? 32'h00C0FFEE : 32'hDEADBEEF, 1'b0};
    tbl[7]  = '{1'b0, 4'b0000, 32'h100, 32'h0, ErrEn ? 32'h0 : 32'hDEADBEEF, ErrEn};
    tbl[8]  = '{1'b1, 4'b1111, 32'h20,  32'h0BADF00D, 32'h0, 1'b0};
    tbl[9]  = '{1'b1, 4'b0000, 32'h20,  32'hFFFFFFFF, 32'h0, 1'b0};
    tbl[10] = '{1'b0, 4'b0000, 32'h20,  32'h0, 32'h0BADF00D, 1'b0};
    tbl[11] = '{1'b1, 4'b1001, 32'h20,  32'h11FFFF22, 32'h0, 1'b0};
    tbl[12] = '{1'b0, 4'b0000, 32'h20,  32'h0, 32'h11ADF022, 1'b0};
    tbl[13] = '{1'b0, 4'b0000, 32'h23,  32'h0, 32'h11ADF022, 1'b0};

    reset = 1'b0;
    #1 reset = 1'b1;
    #1;
    check("rst_ready", 32'(bus0.ready), 32'd0);
    check("rst_busy", 32'(bus0.busy), 32'd0);
    check("rst_err", 32'(bus0.err), 32'd0);
    check("rst_rdata", bus0.read_data, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    foreach (tbl[i]) begin
      txn(0, tbl[i].we, tbl[i].be, tbl[i].addr, tbl[i].wdata, tbl[i].rdata, tbl[i].err, 3);
    end

    txn(1, 1'b1, 4'b1111, 32'h14, 32'h12345678, 32'h0, 1'b0, 1);
    txn(1, 1'b0, 4'b0000, 32'h14, 32'h0, 32'h12345678, 1'b0, 1);

    // Asynchronous reset pulse between clock edges clears the held read word at once.
    @(negedge clk);
    check("pre_rst_rdata", bus0.read_data, 32'h11ADF022);
    reset = 1'b1;
    #1;
    check("async_ready", 32'(bus0.ready), 32'd0);
    check("async_busy", 32'(bus0.busy), 32'd0);
    check("async_err", 32'(bus0.err), 32'd0);
    check("async_rdata", bus0.read_data, 32'd0);
    #1 reset = 1'b0;
    @(posedge clk);

    // A req pulse while busy is ignored: its store must not land.
    rb = rdy0;
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 4'b1111, 32'h14, 32'hCAFEF00D);
    @(posedge clk);
    q0.push_back('{is_read: 1'b0, rdata: 32'h0, err: 1'b0});
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0);
    @(negedge clk);
    check("busy_in_wait", 32'(bus0.busy), 32'd1);
    drive(0, 1'b1, 1'b1, 4'b1111, 32'h14, 32'hFFFFFFFF);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0);
    repeat (6) @(posedge clk);
    #1;
    check("busy_req_ignored", 32'(rdy0 - rb), 32'd1);
    txn(0, 1'b0, 4'b0000, 32'h14, 32'h0, 32'hCAFEF00D, 1'b0, 3);

    // req held for 12 cycles: three back-to-back reads, one every WAIT+2 cycles.
    rb = rdy0;
    st0.delete();
    for (int i = 0; i < 3; i++) q0.push_back('{is_read: 1'b1, rdata: 32'hCAFEF00D, err: 1'b0});
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 4'b0000, 32'h14, 32'h0);
    repeat (12) @(posedge clk);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0);
    repeat (6) @(posedge clk);
    #1;
    check("held_req_strobes", 32'(rdy0 - rb), 32'd3);
    if (st0.size() >= 3) begin
      check("held_gap1", 32'(st0[1] - st0[0]), 32'd4);
      check("held_gap2", 32'(st0[2] - st0[1]), 32'd4);
    end

    // Reset in the first WAIT cycle abandons the write.
    rb = rdy0;
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 4'b1111, 32'h20, 32'h55AA55AA);
    @(posedge clk);
    #1 drive(0, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_busy", 32'(bus0.busy), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("midrst_no_ready", 32'(rdy0 - rb), 32'd0);
    txn(0, 1'b0, 4'b0000, 32'h20, 32'h0, 32'h11ADF022, 1'b0, 3);

    // Reset held across the commit edge: no store.
    rb = rdy0;
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 4'b1111, 32'h20, 32'h77777777);
    @(posedge clk);
    #1 drive(0, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("commitrst_no_ready", 32'(rdy0 - rb), 32'd0);
    txn(0, 1'b0, 4'b0000, 32'h20, 32'h0, 32'h11ADF022, 1'b0, 3);

    repeat (3) @(posedge clk);
    check("q0_drained", 32'(q0.size()), 32'd0);
    check("q1_drained", 32'(q1.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
